// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the sequential ALU.
// ALU_FAST_MULT_EN: when defined, MULT is a single-cycle combinational multiply.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MULT = 4'd2,
        DIV  = 4'd3,
        SLL  = 4'd4,
        SRL  = 4'd5,
        AND  = 4'd6,
        OR   = 4'd7,
        XOR  = 4'd8,
        NOT  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // Ops that go through BUSY; everything else (including unused encodings) is single-cycle.
    function automatic logic is_multicycle(alu_op_t op);
`ifdef ALU_FAST_MULT_EN
        return (op == DIV);
`else
        return (op == MULT) || (op == DIV);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: operand/result handshake bundle between decode and writeback.
interface alu_seq_unit_if #(
    parameter int unsigned N = 32
) ();
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     resultado;
    alu_flags_t       flags;
    logic             div_by_zero;

    // Upstream/downstream side driving operands and consuming results.
    modport master (
        output in_valid, ALUControl, a, b, out_ready,
        input  in_ready, out_valid, resultado, flags, div_by_zero
    );

    // The ALU itself.
    modport slave (
        input  in_valid, ALUControl, a, b, out_ready,
        output in_ready, out_valid, resultado, flags, div_by_zero
    );

endinterface

// File: rtl/alu_seq_div.sv
// alu_seq_div: unsigned restoring divider, one quotient bit per cycle, N cycles.
// A divisor of zero naturally yields an all-ones quotient (every trial subtract fits).
module alu_seq_div #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic         div_by_zero
);
    localparam int unsigned SW = $clog2(N);
    localparam logic [SW-1:0] LastCnt = SW'(N - 1);

    logic [N-1:0]  rem_q, quo_q, dvsr_q;
    logic [N-1:0]  rem_n, quo_n, diff;
    logic [N:0]    shifted;
    logic [SW-1:0] cnt_q;
    logic          busy_q, dbz_q, fits;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted = {rem_q, quo_q[N-1]};
        fits    = (shifted >= {1'b0, dvsr_q});
        // Only used when fits, so the true difference is below 2^N.
        diff    = shifted[N-1:0] - dvsr_q;
        rem_n   = fits ? diff : shifted[N-1:0];
        quo_n   = {quo_q[N-2:0], fits};
    end

    // done and quotient are presented during the final step so the caller captures them
    // on the same edge that step completes.
    assign done        = busy_q && (cnt_q == LastCnt);
    assign quotient    = quo_n;
    assign div_by_zero = dbz_q;

    // Divider datapath and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            dbz_q  <= (divisor == '0);
        end else if (busy_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + SW'(1);
            if (cnt_q == LastCnt) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with single-cycle ops and iterative MULT/DIV.
// ALU_FAST_MULT_EN: when defined, MULT uses a combinational multiply (single-cycle).
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_unit_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = SW + 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    alu_state_t    state_q, state_d;
    alu_op_t       op_q, op_d, op_in;
    logic [N-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [N-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    alu_flags_t    flags_q, flags_d;
    logic          dbz_q, dbz_d;

    logic          accept, div_start, div_done, div_dbz, last;
    logic [N-1:0]  div_quo, mul_acc_n, mc_res;
    logic [N-1:0]  sc_res;
    logic          sc_c, sc_v;
    logic [N:0]    sum_ext, sub_ext, sll_ext, srl_ext;
    logic [SW-1:0] shamt;

    assign op_in  = alu_op_t'(bus.ALUControl);
    assign accept = bus.in_valid && (state_q == IDLE);
    assign shamt  = bus.b[SW-1:0];

    assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
    // ARM-style subtract: carry out is NOT borrow.
    assign sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);
    // The extra bit catches the last bit shifted out; zero amount leaves it 0.
    assign sll_ext = {1'b0, bus.a} << shamt;
    assign srl_ext = {bus.a, 1'b0} >> shamt;

    // Shift-add step: a_q is the shifting multiplicand, b_q the shifting multiplier.
    assign mul_acc_n = acc_q + (b_q[0] ? a_q : '0);

    assign last   = (op_q == DIV) ? div_done : (cnt_q == LastCnt);
    assign mc_res = (op_q == DIV) ? div_quo : mul_acc_n;

    alu_seq_div #(
        .N(N)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .start      (div_start),
        .dividend   (bus.a),
        .divisor    (bus.b),
        .done       (div_done),
        .quotient   (div_quo),
        .div_by_zero(div_dbz)
    );

    // Single-cycle result and C/V for the op on the input bus.
    always_comb begin
        sc_res = sum_ext[N-1:0];
        sc_c   = sum_ext[N];
        sc_v   = (bus.a[N-1] == bus.b[N-1]) && (sum_ext[N-1] != bus.a[N-1]);
        case (op_in)
            SUB: begin
                sc_res = sub_ext[N-1:0];
                sc_c   = sub_ext[N];
                sc_v   = (bus.a[N-1] != bus.b[N-1]) && (sub_ext[N-1] != bus.a[N-1]);
            end
            MULT: begin
`ifdef ALU_FAST_MULT_EN
                sc_res = bus.a * bus.b;
`else
                sc_res = '0;
`endif
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            DIV: begin
                sc_res = '0;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            SLL: begin
                sc_res = sll_ext[N-1:0];
                sc_c   = sll_ext[N];
                sc_v   = 1'b0;
            end
            SRL: begin
                sc_res = srl_ext[N:1];
                sc_c   = srl_ext[0];
                sc_v   = 1'b0;
            end
            AND: begin
                sc_res = bus.a & bus.b;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            OR: begin
                sc_res = bus.a | bus.b;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            XOR: begin
                sc_res = bus.a ^ bus.b;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            NOT: begin
                sc_res = ~bus.a;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
            default: ;
        endcase
    end

    // FSM next-state, operand latching, iteration and result capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
        dbz_d     = dbz_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = op_in;
                    if (is_multicycle(op_in)) begin
                        state_d   = BUSY;
                        a_d       = bus.a;
                        b_d       = bus.b;
                        acc_d     = '0;
                        cnt_d     = '0;
                        div_start = (op_in == DIV);
                    end else begin
                        state_d  = DONE;
                        result_d = sc_res;
                        flags_d  = '{n: sc_res[N-1], z: (sc_res == '0), c: sc_c, v: sc_v};
                        dbz_d    = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                acc_d = mul_acc_n;
                if (last) begin
                    state_d  = DONE;
                    result_d = mc_res;
                    flags_d  = '{n: mc_res[N-1], z: (mc_res == '0), c: 1'b0, v: 1'b0};
                    dbz_d    = (op_q == DIV) && div_dbz;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.resultado   = result_q;
    assign bus.flags       = flags_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit with an integer reference model.
module tb_alu_seq_unit;
    localparam int unsigned N = 8;
`ifdef ALU_FAST_MULT_EN
    localparam bit FastMult = 1'b1;
`else
    localparam bit FastMult = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         dbz;
        int           acc;
        int           lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   ncmp;
    int   nerr;
    int   ready_mode;
    exp_t sb[$];

    alu_seq_unit_if #(.N(N)) bus ();

    alu_seq_unit #(
        .N(N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op);
        return (op == 4'd3) || ((op == 4'd2) && !FastMult);
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic void ref_model(input logic [3:0] op, input logic [N-1:0] a,
                                      input logic [N-1:0] b, output logic [N-1:0] res,
                                      output logic [3:0] flg, output logic dbz);
        longint ua, ub, sa, sb, r, m;
        int amt;
        logic c, v;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        m   = longint'(1) << N;
        amt = int'(ub % N);
        c   = 1'b0;
        v   = 1'b0;
        dbz = 1'b0;
        case (op)
            4'd1: begin
                r   = ua - ub;
                res = N'(r);
                c   = (ua >= ub);
                v   = ((sa - sb) > (m / 2 - 1)) || ((sa - sb) < -(m / 2));
            end
            4'd2: res = N'(ua * ub);
            4'd3: begin
                if (ub == 0) begin
                    res = '1;
                    dbz = 1'b1;
                end else begin
                    res = N'(ua / ub);
                end
            end
            4'd4: begin
                res = N'(ua << amt);
                c   = (amt != 0) && (((ua >> (N - amt)) & 1) != 0);
            end
            4'd5: begin
                res = N'(ua >> amt);
                c   = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd9: res = ~a;
            default: begin
                r   = ua + ub;
                res = N'(r);
                c   = (r >= m);
                v   = ((sa + sb) > (m / 2 - 1)) || ((sa + sb) < -(m / 2));
            end
        endcase
        flg = {res[N-1], (res == '0), c, v};
    endfunction

    // out_ready policy: 0 = held low, 1 = held high, otherwise random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pop on each new result, then check it stays put until transferred.
    bit           checked;
    logic [N-1:0] hold_res;
    logic [3:0]   hold_flg;
    logic         hold_dbz;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            checked = 1'b0;
        end else if (bus.out_valid) begin
            if (!checked) begin
                if (sb.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_output: got result 0x%0h with no op pending",
                             bus.resultado);
                end else begin
                    e = sb.pop_front();
                    check("resultado", 32'(bus.resultado), 32'(e.res));
                    check("flags", 32'(bus.flags), 32'(e.flg));
                    check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    hold_res = e.res;
                    hold_flg = e.flg;
                    hold_dbz = e.dbz;
                end
                checked = 1'b1;
            end else begin
                check("hold_stable", {19'd0, bus.div_by_zero, bus.flags, bus.resultado},
                      {19'd0, hold_dbz, hold_flg, hold_res});
            end
            if (bus.out_ready) checked = 1'b0;
        end else begin
            checked = 1'b0;
        end
    end

    // Present one op, wait (bounded) for acceptance, log the expected response.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        bit   got;
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
        got            = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            ncmp++;
            nerr++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end else begin
            ref_model(op, a, b, e.res, e.flg, e.dbz);
            e.acc = cyc;
            e.lat = is_multi(op) ? int'(N) + 1 : 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   op;
        logic [N-1:0] ra, rb;
        ncmp           = 0;
        nerr           = 0;
        cyc            = 0;
        checked        = 1'b0;
        ready_mode     = 1;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.ALUControl = 4'd0;
        bus.a          = '0;
        bus.b          = '0;
        bus.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_resultado", 32'(bus.resultado), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(4'd0, 8'h7F, 8'h01);
        issue(4'd1, 8'h05, 8'h05);
        issue(4'd2, 8'h0D, 8'h0B);
        issue(4'd3, 8'hC8, 8'h07);
        issue(4'd3, 8'h10, 8'h00);
        issue(4'd5, 8'h81, 8'h00);
        issue(4'd5, 8'h81, 8'h07);
        issue(4'd9, 8'h5A, 8'h00);
        drain();

        // Consumer stalls; a second request during DONE must be ignored.
        ready_mode = 0;
        issue(4'd4, 8'h81, 8'h01);
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'd0;
        bus.a          = 8'h11;
        bus.b          = 8'h22;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        drain();

        // Reset three cycles into a divide drops it.
        issue(4'd3, 8'hC8, 8'h07);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_resultado", 32'(bus.resultado), 32'd0);
        check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        issue(4'd0, 8'h12, 8'h34);
        drain();

        // Randomized ops with random back-pressure.
        ready_mode = 2;
        repeat (60) begin
            op = 4'($urandom_range(0, 15));
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            issue(op, ra, rb);
        end
        ready_mode = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
